ac97_playback_tx: RTL and testbench

AC97_PLAYBACK_TX -- requirements
Module: ac97_playback_tx

---
 rtl/ac97_pkg.sv | 52 +++++
 rtl/ac97_slot_shifter.sv | 26 ++
 rtl/ac97_playback_tx.sv | 200 ++++++++++++++++++++
 tb/tb_ac97_playback_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ac97_pkg.sv
// Shared AC-link constants, types and helpers for the AC97 playback transmitter.
package ac97_pkg;

    localparam int AC97_FRAME_BITS = 256;
    localparam int SLOT0_BITS      = 16;
    localparam int SLOT_BITS       = 20;
    localparam int NUM_SLOTS       = 12;

    localparam int TAG_FRAME = 15;
    localparam int TAG_SLOT1 = 14;
    localparam int TAG_SLOT2 = 13;
    localparam int TAG_SLOT3 = 12;
    localparam int TAG_SLOT4 = 11;

    localparam logic [6:0] REG_MASTER_VOL  = 7'h02;
    localparam logic [6:0] REG_LINE_IN_VOL = 7'h10;
    localparam logic [6:0] REG_PCM_OUT_VOL = 7'h18;
    localparam logic [6:0] REG_RECORD_SEL  = 7'h1A;

    typedef enum logic [1:0] {
        CMD_EMPTY,
        CMD_PENDING,
        CMD_SENDING
    } cmd_state_t;

    typedef struct packed {
        logic        cmd_tag;
        logic        pcm_tag;
        logic [6:0]  addr;
        logic [15:0] data;
        logic [15:0] left;
        logic [15:0] right;
    } frame_t;

    // First bit-counter value of slot n (slot 0 starts at 0).
    function automatic int slot_start(input int n);
        return (n == 0) ? 0 : SLOT0_BITS + SLOT_BITS * (n - 1);
    endfunction

    function automatic logic [15:0] slot0_word(input frame_t f, input logic [1:0] codec_id);
        logic [15:0] w;
        w            = '0;
        w[TAG_SLOT1] = f.cmd_tag;
        w[TAG_SLOT2] = f.cmd_tag;
        w[TAG_SLOT3] = f.pcm_tag;
        w[TAG_SLOT4] = f.pcm_tag;
        w[TAG_FRAME] = |w[TAG_SLOT1:TAG_SLOT4];
        w[1:0]       = codec_id;
        return w;
    endfunction

endpackage

// File: rtl/ac97_slot_shifter.sv
// 20-bit MSB-first shift register with parallel load; drives one AC-link slot at a time.
module ac97_slot_shifter
    import ac97_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [SLOT_BITS-1:0] load_data,
    output logic                 serial_out
);

    logic [SLOT_BITS-1:0] shift_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_reg <= '0;
        end else if (load) begin
            shift_reg <= load_data;
        end else begin
            shift_reg <= {shift_reg[SLOT_BITS-2:0], 1'b0};
        end
    end

    assign serial_out = shift_reg[SLOT_BITS-1];

endmodule

// File: rtl/ac97_playback_tx.sv
// AC97 AC-link output side: builds slot 0 tags, one codec register write and one
// stereo PCM pair per frame, and serialises them on aSDO with a matching aSync.
module ac97_playback_tx
    import ac97_pkg::*;
#(
    parameter int         FRAME_BITS = AC97_FRAME_BITS,
    parameter logic [1:0] CODEC_ID   = 2'b00
) (
    input  logic        fclk,
    input  logic        freset_n,
    input  logic [15:0] fAudLOut,
    input  logic [15:0] fAudROut,
    input  logic        fPcmValid,
    output logic        fPcmReady,
    input  logic        fCmdValid,
    input  logic [6:0]  fCmdAddr,
    input  logic [15:0] fCmdData,
    output logic        fCmdReady,
    output logic        fCmdDone,
    output logic        fUnderrun,
    output logic        aSDO,
    output logic        aSync,
    output logic        aReset
);

    localparam int              BC_W    = $clog2(FRAME_BITS);
    localparam logic [BC_W-1:0] LAST_BC = BC_W'(FRAME_BITS - 1);

    logic [BC_W-1:0] bc_reg;
    logic [BC_W-1:0] bc_next;
    logic            latch;

    assign latch   = (bc_reg == LAST_BC);
    assign bc_next = latch ? '0 : bc_reg + BC_W'(1);

    always_ff @(posedge fclk) begin
        if (!freset_n) begin
            bc_reg <= LAST_BC;
        end else begin
            bc_reg <= bc_next;
        end
    end

    // Sample buffer: a pair offered in the latch cycle lands after the latch has read it.
    logic        pcm_full_reg;
    logic [15:0] pcm_left_reg;
    logic [15:0] pcm_right_reg;
    logic        pcm_take;

    assign fPcmReady = ~pcm_full_reg;
    assign pcm_take  = fPcmValid & ~pcm_full_reg;

    always_ff @(posedge fclk) begin
        if (!freset_n) begin
            pcm_full_reg <= 1'b0;
        end else if (pcm_take) begin
            pcm_full_reg <= 1'b1;
        end else if (latch) begin
            pcm_full_reg <= 1'b0;
        end
    end

    always_ff @(posedge fclk) begin
        if (pcm_take) begin
            pcm_left_reg  <= fAudLOut;
            pcm_right_reg <= fAudROut;
        end
    end

    // Command buffer stays occupied while its frame is on the wire.
    cmd_state_t  cmd_state_reg;
    cmd_state_t  cmd_state_next;
    logic        cmd_take;
    logic        cmd_done;
    logic [6:0]  cmd_addr_reg;
    logic [15:0] cmd_data_reg;

    always_ff @(posedge fclk) begin
        if (!freset_n) begin
            cmd_state_reg <= CMD_EMPTY;
        end else begin
            cmd_state_reg <= cmd_state_next;
        end
    end

    always_comb begin
        cmd_state_next = cmd_state_reg;
        cmd_take       = 1'b0;
        cmd_done       = 1'b0;
        case (cmd_state_reg)
            CMD_EMPTY: begin
                if (fCmdValid) begin
                    cmd_take       = 1'b1;
                    cmd_state_next = CMD_PENDING;
                end
            end
            CMD_PENDING: begin
                if (latch) begin
                    cmd_state_next = CMD_SENDING;
                end
            end
            CMD_SENDING: begin
                if (latch) begin
                    cmd_done       = 1'b1;
                    cmd_state_next = CMD_EMPTY;
                end
            end
            default: cmd_state_next = CMD_EMPTY;
        endcase
    end

    always_ff @(posedge fclk) begin
        if (cmd_take) begin
            cmd_addr_reg <= fCmdAddr;
            cmd_data_reg <= fCmdData;
        end
    end

    assign fCmdReady = (cmd_state_reg == CMD_EMPTY);
    assign fCmdDone  = freset_n & cmd_done;
    assign fUnderrun = freset_n & latch & ~pcm_full_reg;

    frame_t frame_reg;
    frame_t frame_next;

    always_comb begin
        frame_next         = '0;
        frame_next.pcm_tag = pcm_full_reg;
        frame_next.cmd_tag = (cmd_state_reg == CMD_PENDING);
        if (pcm_full_reg) begin
            frame_next.left  = pcm_left_reg;
            frame_next.right = pcm_right_reg;
        end
        if (cmd_state_reg == CMD_PENDING) begin
            frame_next.addr = cmd_addr_reg;
            frame_next.data = cmd_data_reg;
        end
    end

    always_ff @(posedge fclk) begin
        if (!freset_n) begin
            frame_reg <= '0;
        end else if (latch) begin
            frame_reg <= frame_next;
        end
    end

    // slot_hit[n] marks the edge that starts slot n; slots past the frame end never start.
    logic [NUM_SLOTS:0] slot_hit;

    generate
        for (genvar gi = 0; gi <= NUM_SLOTS; gi++) begin : g_slot_hit
            if (slot_start(gi) < FRAME_BITS) begin : g_in
                assign slot_hit[gi] = (bc_next == BC_W'(slot_start(gi)));
            end else begin : g_out
                assign slot_hit[gi] = 1'b0;
            end
        end
    endgenerate

    logic                 shift_load;
    logic [SLOT_BITS-1:0] load_word;

    // Slot 0 is loaded on the latch edge itself, so it is built from the incoming frame.
    always_comb begin
        load_word = '0;
        if (slot_hit[0]) begin
            load_word = {slot0_word(frame_next, CODEC_ID), 4'b0};
        end else if (slot_hit[1]) begin
            load_word = {1'b0, frame_reg.addr, 12'b0};
        end else if (slot_hit[2]) begin
            load_word = {frame_reg.data, 4'b0};
        end else if (slot_hit[3]) begin
            load_word = {frame_reg.left, 4'b0};
        end else if (slot_hit[4]) begin
            load_word = {frame_reg.right, 4'b0};
        end
    end

    assign shift_load = |slot_hit;

    ac97_slot_shifter u_shifter (
        .clk        (fclk),
        .reset_n    (freset_n),
        .load       (shift_load),
        .load_data  (load_word),
        .serial_out (aSDO)
    );

    always_ff @(posedge fclk) begin
        if (!freset_n) begin
            aSync  <= 1'b0;
            aReset <= 1'b0;
        end else begin
            aSync  <= (bc_next < BC_W'(SLOT0_BITS));
            aReset <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ac97_playback_tx.sv
// Directed bench: captures whole AC-link frames from aSDO/aSync and checks slot contents,
// handshakes, pulses and reset behaviour against hand-computed values.
module tb_ac97_playback_tx;

    logic        fclk;
    logic        freset_n;
    logic [15:0] fAudLOut;
    logic [15:0] fAudROut;
    logic        fPcmValid;
    logic        fPcmReady;
    logic        fCmdValid;
    logic [6:0]  fCmdAddr;
    logic [15:0] fCmdData;
    logic        fCmdReady;
    logic        fCmdDone;
    logic        fUnderrun;
    logic        aSDO;
    logic        aSync;
    logic        aReset;

    ac97_playback_tx dut (
        .fclk      (fclk),
        .freset_n  (freset_n),
        .fAudLOut  (fAudLOut),
        .fAudROut  (fAudROut),
        .fPcmValid (fPcmValid),
        .fPcmReady (fPcmReady),
        .fCmdValid (fCmdValid),
        .fCmdAddr  (fCmdAddr),
        .fCmdData  (fCmdData),
        .fCmdReady (fCmdReady),
        .fCmdDone  (fCmdDone),
        .fUnderrun (fUnderrun),
        .aSDO      (aSDO),
        .aSync     (aSync),
        .aReset    (aReset)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    int vectors;
    int miscompares;
    int bc_m;
    int done_cnt;
    int done_bc;
    int und_cnt;
    int cmd_acc_bc;
    logic frame_bits [0:255];
    logic sync_bits  [0:255];
    logic [31:0] pcm_q [$];
    logic [22:0] cmd_q [$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic present();
        logic [31:0] p;
        logic [22:0] c;
        if (pcm_q.size() > 0) begin
            p         = pcm_q[0];
            fPcmValid = 1'b1;
            fAudLOut  = p[31:16];
            fAudROut  = p[15:0];
        end else begin
            fPcmValid = 1'b0;
        end
        if (cmd_q.size() > 0) begin
            c         = cmd_q[0];
            fCmdValid = 1'b1;
            fCmdAddr  = c[22:16];
            fCmdData  = c[15:0];
        end else begin
            fCmdValid = 1'b0;
        end
    endtask

    task automatic tick();
        logic pcm_x;
        logic cmd_x;
        int   pre;
        pcm_x = fPcmValid && fPcmReady;
        cmd_x = fCmdValid && fCmdReady;
        pre   = bc_m;
        @(posedge fclk);
        #1;
        bc_m = (bc_m == 255) ? 0 : bc_m + 1;
        if (pcm_x) void'(pcm_q.pop_front());
        if (cmd_x) begin
            void'(cmd_q.pop_front());
            cmd_acc_bc = pre;
        end
        present();
        frame_bits[bc_m] = aSDO;
        sync_bits[bc_m]  = aSync;
        if (fCmdDone === 1'b1) begin
            done_cnt++;
            done_bc = bc_m;
        end
        if (fUnderrun === 1'b1) und_cnt++;
    endtask

    task automatic run_frame();
        done_cnt = 0;
        done_bc  = -1;
        und_cnt  = 0;
        repeat (256) tick();
    endtask

    function automatic logic [19:0] get_slot(input int n);
        logic [19:0] v;
        int s;
        v = '0;
        if (n == 0) begin
            for (int i = 0; i < 16; i++) v = {v[18:0], frame_bits[i]};
        end else begin
            s = 16 + 20 * (n - 1);
            for (int i = 0; i < 20; i++) v = {v[18:0], frame_bits[s + i]};
        end
        return v;
    endfunction

    function automatic int ones_from(input int s);
        int n;
        n = 0;
        for (int i = s; i < 256; i++) if (frame_bits[i] !== 1'b0) n++;
        return n;
    endfunction

    function automatic int sync_errs();
        int n;
        n = 0;
        for (int i = 0; i < 256; i++) if (sync_bits[i] !== (i < 16)) n++;
        return n;
    endfunction

    logic [31:0] pairs [4];

    initial begin
        vectors     = 0;
        miscompares = 0;
        bc_m        = 255;
        cmd_acc_bc  = -1;
        freset_n    = 1'b0;
        fAudLOut    = '0;
        fAudROut    = '0;
        fPcmValid   = 1'b0;
        fCmdValid   = 1'b0;
        fCmdAddr    = '0;
        fCmdData    = '0;
        pairs[0] = {16'h1111, 16'hEEEE};
        pairs[1] = {16'h2222, 16'hDDDD};
        pairs[2] = {16'h0001, 16'hFFFF};
        pairs[3] = {16'h7FFF, 16'h8000};

        repeat (3) tick();
        check("rst_sdo",       32'(aSDO),      32'd0);
        check("rst_sync",      32'(aSync),     32'd0);
        check("rst_areset",    32'(aReset),    32'd0);
        check("rst_cmd_done",  32'(fCmdDone),  32'd0);
        check("rst_underrun",  32'(fUnderrun), 32'd0);
        check("rst_pcm_ready", 32'(fPcmReady), 32'd1);
        check("rst_cmd_ready", 32'(fCmdReady), 32'd1);

        // Release: the current cycle is the latch of frame 0.
        freset_n = 1'b1;
        bc_m     = 255;
        #1;
        check("first_latch_underrun", 32'(fUnderrun), 32'd1);

        // Frame A: idle link.
        run_frame();
        check("A_areset",   32'(aReset),      32'd1);
        check("A_slot0",    32'(get_slot(0)), 32'h0000);
        check("A_ones",     32'(ones_from(0)), 32'd0);
        check("A_sync",     32'(sync_errs()), 32'd0);
        check("A_underrun", 32'(und_cnt),     32'd1);

        // Offer sample and command in the latch cycle: they skip frame B.
        pcm_q.push_back({16'h8001, 16'h7FFE});
        cmd_q.push_back({7'h02, 16'h0808});
        present();
        #1;
        check("A_latch_pcm_ready", 32'(fPcmReady), 32'd1);
        run_frame();
        check("B_slot0",    32'(get_slot(0)), 32'h0000);
        check("B_slot3",    32'(get_slot(3)), 32'h00000);
        check("B_underrun", 32'(und_cnt),     32'd0);
        check("B_done",     32'(done_cnt),    32'd0);
        check("B_pcm_taken", 32'(pcm_q.size()), 32'd0);

        // Frame C carries both.
        run_frame();
        check("C_slot0",    32'(get_slot(0)), 32'hF800);
        check("C_slot1",    32'(get_slot(1)), 32'h02000);
        check("C_slot2",    32'(get_slot(2)), 32'h08080);
        check("C_slot3",    32'(get_slot(3)), 32'h80010);
        check("C_slot4",    32'(get_slot(4)), 32'h7FFE0);
        check("C_tail_zero", 32'(ones_from(96)), 32'd0);
        check("C_sync",     32'(sync_errs()), 32'd0);
        check("C_done_cnt", 32'(done_cnt),    32'd1);
        check("C_done_bc",  32'(done_bc),     32'd255);
        check("C_underrun", 32'(und_cnt),     32'd1);

        // Next command offered while fCmdDone is high: accepted only on bc 0.
        cmd_q.push_back({7'h10, 16'h1F1F});
        present();
        #1;
        check("C_end_cmd_ready", 32'(fCmdReady), 32'd0);
        run_frame();
        check("D_cmd_acc_bc", 32'(cmd_acc_bc), 32'd0);
        check("D_slot0",      32'(get_slot(0)), 32'h0000);
        check("D_underrun",   32'(und_cnt),     32'd1);
        check("D_done",       32'(done_cnt),    32'd0);

        // Four pairs queued at D's latch: first lands in F.
        for (int k = 0; k < 4; k++) pcm_q.push_back(pairs[k]);
        present();
        run_frame();
        check("E_slot0",    32'(get_slot(0)), 32'hE000);
        check("E_slot1",    32'(get_slot(1)), 32'h10000);
        check("E_slot2",    32'(get_slot(2)), 32'h1F1F0);
        check("E_slot3",    32'(get_slot(3)), 32'h00000);
        check("E_underrun", 32'(und_cnt),     32'd0);
        check("E_done",     32'(done_cnt),    32'd1);

        for (int k = 0; k < 4; k++) begin
            run_frame();
            check($sformatf("S%0d_slot0", k), 32'(get_slot(0)), 32'h9800);
            check($sformatf("S%0d_slot3", k), 32'(get_slot(3)), {12'h0, pairs[k][31:16], 4'h0});
            check($sformatf("S%0d_slot4", k), 32'(get_slot(4)), {12'h0, pairs[k][15:0], 4'h0});
            check($sformatf("S%0d_underrun", k), 32'(und_cnt), (k == 3) ? 32'd1 : 32'd0);
        end

        // Command offered in I's latch cycle: absent from J, on the wire in K.
        cmd_q.push_back({7'h1A, 16'h0404});
        present();
        run_frame();
        check("J_slot0", 32'(get_slot(0)), 32'h0000);
        repeat (101) tick();
        check("K_bc", 32'(bc_m), 32'd100);
        freset_n = 1'b0;
        done_cnt = 0;
        repeat (4) tick();
        check("mid_rst_sdo",       32'(aSDO),      32'd0);
        check("mid_rst_sync",      32'(aSync),     32'd0);
        check("mid_rst_areset",    32'(aReset),    32'd0);
        check("mid_rst_cmd_ready", 32'(fCmdReady), 32'd1);
        check("mid_rst_done",      32'(done_cnt),  32'd0);

        freset_n = 1'b1;
        bc_m     = 255;
        #1;
        check("rel_underrun", 32'(fUnderrun), 32'd1);
        check("rel_cmd_done", 32'(fCmdDone),  32'd0);
        run_frame();
        check("L_slot0", 32'(get_slot(0)), 32'h0000);
        check("L_ones",  32'(ones_from(0)), 32'd0);
        check("L_sync",  32'(sync_errs()), 32'd0);
        check("L_done",  32'(done_cnt),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
